pwrmgr_seq: RTL and testbench
=============================

Name: pwrmgr_seq

Overview:
- Parametrised power-sequencing manager that sits between board pins and the SoC core.
- Qualifies a debounced active-low wake request, then holds the SoC in reset for a fixed stretch before releasing it.
- Services SoC power-off requests and enforces a minimum off time before the next wake is accepted.
- Forces N gated SoC outputs to an idle pattern whenever the SoC is not running.

Parameters:
- WAKE_DEBOUNCE, 4: consecutive low samples of wake_n required to wake; legal range ≥1.
- RESET_HOLD_CYCLES, 8: cycles soc_resetn stays low after wake is qualified; legal range ≥1.
- COOLDOWN_CYCLES, 16: minimum cycles off after poweroff before wake sampling resumes; 0 means skip cooldown.
- N_GATED, 2: number of gated SoC output lines.
- IDLE_VALUE, {N_GATED{1'b1}}: value driven on gated_out when not running.
- BOOT_COUNT_WIDTH, 8: width of the saturating boot counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- wake_n  in  1  active-low wake request, synchronous to clk (e.g. UART CTS).
- poweroff_rq  in  1  SoC power-off request.
- soc_in  in  N_GATED  raw SoC outputs to be gated.
- gated_out  out  N_GATED  gated outputs to the pins.
- soc_resetn  out  1  active-low reset to the SoC.
- running  out  1  high in RUNNING.
- state  out  2  current state: EMBRYO=0, RESET_HOLD=1, RUNNING=2, COOLDOWN=3.
- boot_count  out  BOOT_COUNT_WIDTH  number of entries into RUNNING, saturating.

Behaviour:
- Async reset (resetn=0):
  - state=EMBRYO; debounce, hold and cooldown counters=0; boot_count=0.
  - Outputs: soc_resetn=0, running=0, gated_out=IDLE_VALUE.
  - Effect is immediate, mid-operation included.
- Counter widths: $clog2(max+1) of the relevant parameter; no wrap.
- EMBRYO:
  - Debounce counter increments on each edge with wake_n=0 and clears on any edge with wake_n=1.
  - On the edge where the counter reaches WAKE_DEBOUNCE (while wake_n=0), go to RESET_HOLD.
  - With WAKE_DEBOUNCE=1, the transition happens on the first low sample.
- RESET_HOLD:
  - Hold counter starts at 0 on entry and counts every edge.
  - After exactly RESET_HOLD_CYCLES edges in this state, go to RUNNING.
  - wake_n and poweroff_rq are ignored.
- RUNNING:
  - boot_count increments on the entry edge and saturates at all-ones.
  - poweroff_rq=1 deasserts soc_resetn combinationally in the same cycle.
  - On the next edge, go to COOLDOWN, or to EMBRYO if COOLDOWN_CYCLES=0.
  - poweroff_rq held high across the transition has no further effect.
- COOLDOWN:
  - Wait exactly COOLDOWN_CYCLES edges, then go to EMBRYO.
  - The debounce counter is held at 0, so wake_n low during cooldown does not count.
  - On entering EMBRYO, the debounce count restarts from 0 even if wake_n is still low.
- soc_resetn: equals resetn && state==RUNNING && !poweroff_rq.
- running: equals state==RUNNING, registered via state.
- gated_out: equals soc_in in RUNNING, otherwise IDLE_VALUE; combinational, no added latency.
- Glitch rule: a single-cycle wake_n high during debounce restarts the count.

Test Plan:
- Defaults, resetn released, wake_n=0 held:
  - State goes EMBRYO→RESET_HOLD on the 4th edge.
  - soc_resetn rises 8 edges later.
  - running=1, boot_count=1.
- Wake glitch: wake_n low 3 cycles, high 1 cycle, low 4 cycles → RESET_HOLD entered only on the 4th edge of the second run (8 edges after the first low).
- In RUNNING, assert poweroff_rq for 1 cycle:
  - soc_resetn=0 in the same cycle; gated_out=2'b11 from the next cycle.
  - COOLDOWN lasts 16 edges with wake_n=0 held.
  - EMBRYO then needs 4 more low edges before RESET_HOLD.
- Gating: in EMBRYO drive soc_in=2'b00 → gated_out=2'b11; in RUNNING drive soc_in=2'b01 → gated_out=2'b01 in the same cycle.
- Async reset asserted mid-RESET_HOLD (between edges):
  - Immediately: state=0, boot_count=0, soc_resetn=0.
  - After release, a full debounce is required again.
- BOOT_COUNT_WIDTH=2, 5 wake/poweroff cycles → boot_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/pwrmgr_seq.sv
// Power-sequencing manager: debounces a wake request, stretches SoC reset,
// services power-off with an enforced cooldown, and idles gated SoC outputs.
module pwrmgr_seq #(
   parameter int unsigned          WAKE_DEBOUNCE     = 4,
   parameter int unsigned          RESET_HOLD_CYCLES = 8,
   parameter int unsigned          COOLDOWN_CYCLES   = 16,
   parameter int unsigned          N_GATED           = 2,
   parameter logic [N_GATED-1:0]   IDLE_VALUE        = {N_GATED{1'b1}},
   parameter int unsigned          BOOT_COUNT_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        wake_n,
   input  logic                        poweroff_rq,
   input  logic [N_GATED-1:0]          soc_in,
   output logic [N_GATED-1:0]          gated_out,
   output logic                        soc_resetn,
   output logic                        running,
   output logic [1:0]                  state,
   output logic [BOOT_COUNT_WIDTH-1:0] boot_count
);

   localparam int unsigned DEB_W   = $clog2(WAKE_DEBOUNCE + 1);
   localparam int unsigned HOLD_W  = $clog2(RESET_HOLD_CYCLES + 1);
   // A zero cooldown still needs a legal (unused) one-bit counter
   localparam int unsigned CD_W    = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
   localparam int unsigned CD_LAST = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      S_EMBRYO     = 2'd0,
      S_RESET_HOLD = 2'd1,
      S_RUNNING    = 2'd2,
      S_COOLDOWN   = 2'd3
   } state_e;

   state_e                      state_q, state_d;
   logic [DEB_W-1:0]            deb_q, deb_d;
   logic [HOLD_W-1:0]           hold_q, hold_d;
   logic [CD_W-1:0]             cd_q, cd_d;
   logic [BOOT_COUNT_WIDTH-1:0] boot_q, boot_d;

   // State and counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_EMBRYO;
         deb_q   <= '0;
         hold_q  <= '0;
         cd_q    <= '0;
         boot_q  <= '0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         cd_q    <= cd_d;
         boot_q  <= boot_d;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      hold_d  = hold_q;
      cd_d    = cd_q;
      boot_d  = boot_q;
      unique case (state_q)
         S_EMBRYO: begin
            if (!wake_n) begin
               if (deb_q == DEB_W'(WAKE_DEBOUNCE - 1)) begin
                  state_d = S_RESET_HOLD;
                  deb_d   = '0;
                  hold_d  = '0;
               end else begin
                  deb_d = deb_q + DEB_W'(1);
               end
            end else begin
               deb_d = '0;
            end
         end
         S_RESET_HOLD: begin
            if (hold_q == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
               state_d = S_RUNNING;
               hold_d  = '0;
               if (boot_q != {BOOT_COUNT_WIDTH{1'b1}}) begin
                  boot_d = boot_q + BOOT_COUNT_WIDTH'(1);
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_RUNNING: begin
            if (poweroff_rq) begin
               deb_d   = '0;
               cd_d    = '0;
               state_d = (COOLDOWN_CYCLES == 0) ? S_EMBRYO : S_COOLDOWN;
            end
         end
         S_COOLDOWN: begin
            // Wake samples during cooldown never count toward debounce
            deb_d = '0;
            if (cd_q == CD_W'(CD_LAST)) begin
               state_d = S_EMBRYO;
               cd_d    = '0;
            end else begin
               cd_d = cd_q + CD_W'(1);
            end
         end
         default: state_d = S_EMBRYO;
      endcase
   end

   // Power-off drops SoC reset in the same cycle, ahead of the state change
   assign running    = (state_q == S_RUNNING);
   assign state      = state_q;
   assign soc_resetn = resetn & running & ~poweroff_rq;
   assign gated_out  = running ? soc_in : IDLE_VALUE;
   assign boot_count = boot_q;

endmodule

// File: tb/tb_pwrmgr_seq.sv
// Self-checking bench for pwrmgr_seq: directed vector table, multi-cycle
// corner sequences, a boundary-parameter instance and a randomized model run.
module tb_pwrmgr_seq;

   localparam int WD   = 4;
   localparam int RH   = 8;
   localparam int CD   = 16;
   localparam int BMAX = 255;

   logic       clk = 1'b0;
   logic       resetn, wake_n, poweroff_rq;
   logic [1:0] soc_in, gated_out, state;
   logic       soc_resetn, running;
   logic [7:0] boot_count;

   logic       resetn_b, wake_b, poff_b;
   logic [1:0] soc_in_b, gated_b, state_b;
   logic       rstn_b, running_b;
   logic [1:0] boot_b;

   int checks = 0;
   int errors = 0;

   int m_state, m_low, m_age, m_boot;

   always #5 clk = ~clk;

   pwrmgr_seq dut (
      .clk(clk), .resetn(resetn), .wake_n(wake_n), .poweroff_rq(poweroff_rq),
      .soc_in(soc_in), .gated_out(gated_out), .soc_resetn(soc_resetn),
      .running(running), .state(state), .boot_count(boot_count)
   );

   pwrmgr_seq #(
      .WAKE_DEBOUNCE(1), .RESET_HOLD_CYCLES(1), .COOLDOWN_CYCLES(0),
      .N_GATED(2), .IDLE_VALUE(2'b10), .BOOT_COUNT_WIDTH(2)
   ) dut_b (
      .clk(clk), .resetn(resetn_b), .wake_n(wake_b), .poweroff_rq(poff_b),
      .soc_in(soc_in_b), .gated_out(gated_b), .soc_resetn(rstn_b),
      .running(running_b), .state(state_b), .boot_count(boot_b)
   );

   typedef struct packed {
      logic       wake_n;
      logic [1:0] soc_in;
      logic [1:0] st;
      logic       rstn;
      logic [1:0] gated;
      logic [7:0] boot;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(input logic w, input logic [1:0] si, input logic [1:0] st,
                               input logic r, input logic [1:0] g, input logic [7:0] b);
      vec_t v;
      v.wake_n = w; v.soc_in = si; v.st = st; v.rstn = r; v.gated = g; v.boot = b;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase number plus cycles spent in it, straight from the rules
   task automatic model_reset();
      m_state = 0; m_low = 0; m_age = 0; m_boot = 0;
   endtask

   task automatic model_edge();
      if (!resetn) begin
         model_reset();
      end else begin
         case (m_state)
            0: if (!wake_n) begin
                  m_low++;
                  if (m_low == WD) begin m_state = 1; m_age = 0; end
               end else m_low = 0;
            1: begin
                  m_age++;
                  if (m_age == RH) begin
                     m_state = 2;
                     if (m_boot < BMAX) m_boot++;
                  end
               end
            2: if (poweroff_rq) begin m_state = (CD == 0) ? 0 : 3; m_age = 0; m_low = 0; end
            default: begin
                  m_age++; m_low = 0;
                  if (m_age == CD) m_state = 0;
               end
         endcase
      end
   endtask

   task automatic check_model(input string tag);
      logic       exp_run;
      logic [1:0] exp_g;
      exp_run = (m_state == 2);
      exp_g   = exp_run ? soc_in : 2'b11;
      chk({tag, ".state"}, state, m_state);
      chk({tag, ".running"}, running, exp_run);
      chk({tag, ".soc_resetn"}, soc_resetn, resetn && exp_run && !poweroff_rq);
      chk({tag, ".gated"}, gated_out, exp_g);
      chk({tag, ".boot"}, boot_count, m_boot);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      tbl[0]  = mk(1'b0, 2'b00, 2'd0, 1'b0, 2'b11, 8'd0);
      tbl[1]  = mk(1'b0, 2'b00, 2'd0, 1'b0, 2'b11, 8'd0);
      tbl[2]  = mk(1'b0, 2'b01, 2'd0, 1'b0, 2'b11, 8'd0);
      tbl[3]  = mk(1'b0, 2'b01, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[4]  = mk(1'b0, 2'b10, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[5]  = mk(1'b1, 2'b10, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[6]  = mk(1'b1, 2'b00, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[7]  = mk(1'b0, 2'b00, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[8]  = mk(1'b0, 2'b00, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[9]  = mk(1'b0, 2'b00, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[10] = mk(1'b0, 2'b00, 2'd1, 1'b0, 2'b11, 8'd0);
      tbl[11] = mk(1'b0, 2'b01, 2'd2, 1'b1, 2'b01, 8'd1);
      tbl[12] = mk(1'b0, 2'b10, 2'd2, 1'b1, 2'b10, 8'd1);
      tbl[13] = mk(1'b0, 2'b00, 2'd2, 1'b1, 2'b00, 8'd1);

      resetn = 1'b0; wake_n = 1'b1; poweroff_rq = 1'b0; soc_in = 2'b00;
      resetn_b = 1'b0; wake_b = 1'b1; poff_b = 1'b0; soc_in_b = 2'b01;
      model_reset();
      #12;
      chk("rst.state", state, 0);
      chk("rst.soc_resetn", soc_resetn, 0);
      chk("rst.running", running, 0);
      chk("rst.gated", gated_out, 2'b11);
      chk("rst.boot", boot_count, 0);
      resetn = 1'b1; resetn_b = 1'b1;

      // Wake, hold, run: wake_n high mid-hold must be ignored
      for (int i = 0; i < 14; i++) begin
         wake_n = tbl[i].wake_n;
         soc_in = tbl[i].soc_in;
         tick();
         chk($sformatf("vec%0d.state", i), state, tbl[i].st);
         chk($sformatf("vec%0d.soc_resetn", i), soc_resetn, tbl[i].rstn);
         chk($sformatf("vec%0d.gated", i), gated_out, tbl[i].gated);
         chk($sformatf("vec%0d.boot", i), boot_count, tbl[i].boot);
      end

      // Power-off: same-cycle reset drop, then cooldown and a fresh debounce
      wake_n = 1'b0; soc_in = 2'b01; poweroff_rq = 1'b1;
      #1;
      chk("poff.same_cycle_rstn", soc_resetn, 0);
      chk("poff.same_cycle_gated", gated_out, 2'b01);
      chk("poff.same_cycle_running", running, 1);
      tick();
      chk("poff.enter_state", state, 3);
      chk("poff.enter_gated", gated_out, 2'b11);
      for (int i = 1; i <= CD; i++) begin
         tick();
         poweroff_rq = 1'b0;
         chk($sformatf("cool%0d.state", i), state, (i < CD) ? 3 : 0);
      end
      for (int j = 1; j <= WD; j++) begin
         tick();
         chk($sformatf("rewake%0d.state", j), state, (j < WD) ? 0 : 1);
      end
      repeat (RH) tick();
      chk("reboot.state", state, 2);
      chk("reboot.boot", boot_count, 2);

      // Async reset in the middle of RESET_HOLD
      poweroff_rq = 1'b1;
      tick();
      poweroff_rq = 1'b0;
      repeat (CD + WD) tick();
      chk("hold_again.state", state, 1);
      repeat (3) tick();
      #3;
      resetn = 1'b0;
      model_reset();
      #1;
      chk("async.state", state, 0);
      chk("async.boot", boot_count, 0);
      chk("async.soc_resetn", soc_resetn, 0);
      chk("async.gated", gated_out, 2'b11);
      tick();
      resetn = 1'b1;

      // Single-cycle glitch restarts the debounce
      begin
         logic pat [8];
         pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
         for (int i = 0; i < 8; i++) begin
            wake_n = pat[i];
            tick();
            chk($sformatf("glitch%0d.state", i), state, (i == 7) ? 1 : 0);
         end
      end
      repeat (RH) tick();
      chk("post_glitch.boot", boot_count, 1);

      // Boundary instance: debounce 1, hold 1, no cooldown, 2-bit saturation
      #1;
      chk("b.idle_gated", gated_b, 2'b10);
      for (int c = 1; c <= 5; c++) begin
         wake_b = 1'b0;
         tick();
         chk($sformatf("b%0d.hold", c), state_b, 1);
         wake_b = 1'b1;
         tick();
         chk($sformatf("b%0d.run", c), state_b, 2);
         chk($sformatf("b%0d.running", c), running_b, 1);
         chk($sformatf("b%0d.boot", c), boot_b, (c < 3) ? c : 3);
         poff_b = 1'b1;
         #1;
         chk($sformatf("b%0d.rstn_drop", c), rstn_b, 0);
         tick();
         chk($sformatf("b%0d.off", c), state_b, 0);
         poff_b = 1'b0;
      end

      // Randomized traffic against the model, with occasional async resets
      for (int n = 0; n < 3000; n++) begin
         if (!resetn) resetn = 1'b1;
         wake_n      = ($urandom_range(0, 9) < 2);
         poweroff_rq = ($urandom_range(0, 15) == 0);
         soc_in      = 2'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            resetn = 1'b0;
            model_reset();
         end
         #1;
         check_model("rnd_pre");
         tick();
         check_model("rnd_post");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
